k6502_bus_trace: RTL and testbench

K6502_BUS_TRACE -- requirements
Module: k6502_bus_trace

---
 rtl/k6502_bus_trace.sv | 180 ++++++++++++++++++
 tb/tb_k6502_bus_trace.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/k6502_bus_trace.sv
`default_nettype none
// ============================================================================
// Module     : k6502_bus_trace
// Description: Passive 6502 bus tracer. It classifies each enabled bus cycle
//              as a write, a done marker (write to 16'hDEAD) or, optionally,
//              an opcode fetch. Each event is pushed as a 26-bit entry
//              {type[1:0], a[15:0], d[7:0]} into a 2^DEPTH_LOG2-entry FIFO
//              that a consumer drains with a valid/ready handshake.
// Revision   : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   DEPTH_LOG2  log2 of the FIFO depth (must be >= 1)
// Build option:
//   K6502_TRACE_FETCH_EN  when defined, sync=1 read cycles are captured as
//                         fetch events (type 2'b10); otherwise sync is ignored
// Ports:
//   clk         single clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   en          capture enable
//   a, d        CPU address / data bus (observed only)
//   rw          CPU bus direction, 1 = write
//   sync        CPU opcode-fetch indicator
//   out_data    head entry {type, a, d}; don't-care while out_valid=0
//   out_valid   FIFO holds at least one entry
//   out_ready   consumer pop request
//   overflow    sticky, set when an event was dropped on a full FIFO
//   drop_count  number of dropped events, saturates at 8'hFF
//   done        sticky, set when the CPU writes to 16'hDEAD
// ============================================================================
module k6502_bus_trace #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] a,
  input  logic [7:0]  d,
  input  logic        rw,
  input  logic        sync,
  output logic [25:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic [7:0]  drop_count,
  output logic        done
);

  localparam int          DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [15:0] DONE_ADDR = 16'hDEAD;
  localparam logic [1:0]  TYPE_WR   = 2'b01;
  localparam logic [1:0]  TYPE_FET  = 2'b10;
  localparam logic [1:0]  TYPE_DONE = 2'b11;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  // Storage is intentionally not reset; the pointers alone define validity.
  logic [25:0]         mem_q [DEPTH];

  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_count_q, drop_count_d;
  logic                done_q, done_d;

  logic                fetch_w;
  logic                event_w;
  logic                done_evt_w;
  logic [1:0]          type_w;
  logic                empty_w;
  logic                full_w;
  logic                pop_w;
  logic                push_w;
  logic                drop_w;

  // --------------------------------------------------------------------------
  // Event classification. A write always wins over a coincident sync so a
  // single cycle never produces two entries.
  // --------------------------------------------------------------------------
`ifdef K6502_TRACE_FETCH_EN
  assign fetch_w = sync & ~rw;
`else
  logic unused_sync;
  assign unused_sync = sync;
  assign fetch_w     = 1'b0;
`endif

  always_comb begin
    event_w    = 1'b0;
    done_evt_w = 1'b0;
    type_w     = TYPE_WR;
    if (en && !done_q) begin
      if (rw) begin
        event_w    = 1'b1;
        done_evt_w = (a == DONE_ADDR);
        type_w     = (a == DONE_ADDR) ? TYPE_DONE : TYPE_WR;
      end else if (fetch_w) begin
        event_w = 1'b1;
        type_w  = TYPE_FET;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FIFO status. The extra MSB on each pointer distinguishes full (MSBs
  // differ, indices equal) from empty (pointers identical).
  // --------------------------------------------------------------------------
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);

  // A pop frees a slot on the same edge, so a full FIFO can still accept a
  // push when the consumer is reading.
  assign pop_w  = ~empty_w & out_ready;
  assign push_w = event_w & (~full_w | pop_w);
  assign drop_w = event_w & full_w & ~pop_w;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    done_d       = done_q;

    if (push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_w) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (drop_w) begin
      overflow_d = 1'b1;
      if (drop_count_q != 8'hFF) begin
        drop_count_d = drop_count_q + 8'd1;
      end
    end
    // done latches even if the marker itself could not be stored.
    if (done_evt_w) begin
      done_d = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers. Reset has priority, so a reset edge neither captures
  // nor pops.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      done_q       <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_w) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {type_w, a, d};
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_data   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign out_valid  = ~empty_w;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_k6502_bus_trace.sv
`default_nettype none
// ============================================================================
// Module     : tb_k6502_bus_trace
// Description: Directed self-checking bench for k6502_bus_trace. Expected
//              entries are queued when a capturing bus cycle is driven and
//              compared against out_data when the consumer pops them.
// Revision   : 1.0 - initial release
// Build option:
//   K6502_TRACE_FETCH_EN  selects fetch-capture expectations
// ============================================================================
module tb_k6502_bus_trace;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] a;
  logic [7:0]  d;
  logic        rw;
  logic        sync;
  logic [25:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        done;

  int checks = 0;
  int errors = 0;
  logic [25:0] sb[$];

  k6502_bus_trace #(.DEPTH_LOG2(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .d          (d),
    .rw         (rw),
    .sync       (sync),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow),
    .drop_count (drop_count),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are driven and outputs sampled
  // 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  // One bus cycle, then the bus returns to idle.
  task automatic bus(input logic wr, input logic sy, input logic [15:0] addr,
                     input logic [7:0] data);
    rw   = wr;
    sync = sy;
    a    = addr;
    d    = data;
    step();
    rw   = 1'b0;
    sync = 1'b0;
    a    = 16'h0000;
    d    = 8'h00;
  endtask

  // Pop everything, comparing each head against the scoreboard.
  task automatic drain(input string tag, output int n);
    logic [25:0] exp;
    int guard;
    n     = 0;
    guard = 0;
    out_ready = 1'b1;
    while (out_valid && guard < 64) begin
      if (sb.size() == 0) begin
        chk({tag, "_extra"}, 32'(out_data), 32'h0);
        exp = '0;
      end else begin
        exp = sb.pop_front();
        chk({tag, "_data"}, 32'(out_data), 32'(exp));
      end
      step();
      n++;
      guard++;
    end
    out_ready = 1'b0;
    chk({tag, "_guard"}, 32'(guard < 64), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    logic [25:0] head;

    rst = 1'b1; en = 1'b0; a = '0; d = '0; rw = 1'b0; sync = 1'b0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    // Disabled capture: nothing stored.
    bus(1'b1, 1'b0, 16'h1234, 8'h77);
    chk("en_low_valid", 32'(out_valid), 32'd0);
    en = 1'b1;

    // Single write.
    sb.push_back({2'b01, 16'h0010, 8'h5A});
    bus(1'b1, 1'b0, 16'h0010, 8'h5A);
    chk("wr_valid", 32'(out_valid), 32'd1);
    drain("wr", n);
    chk("wr_count", 32'(n), 32'd1);
    chk("wr_valid_after", 32'(out_valid), 32'd0);

    // Fetch cycle.
`ifdef K6502_TRACE_FETCH_EN
    sb.push_back({2'b10, 16'h8000, 8'hA9});
    bus(1'b0, 1'b1, 16'h8000, 8'hA9);
    chk("fetch_valid", 32'(out_valid), 32'd1);
    drain("fetch", n);
    chk("fetch_count", 32'(n), 32'd1);
`else
    bus(1'b0, 1'b1, 16'h8000, 8'hA9);
    chk("fetch_ignored", 32'(out_valid), 32'd0);
`endif

    // Write with coincident sync: exactly one write entry.
    sb.push_back({2'b01, 16'h4321, 8'h3C});
    bus(1'b1, 1'b1, 16'h4321, 8'h3C);
    drain("wr_sync", n);
    chk("wr_sync_count", 32'(n), 32'd1);

    // Overflow: 20 writes into a 16-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) begin
      if (i < 16) sb.push_back({2'b01, 16'h0100 + 16'(i), 8'(i)});
      bus(1'b1, 1'b0, 16'h0100 + 16'(i), 8'(i));
    end
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd4);
    chk("ovf_valid", 32'(out_valid), 32'd1);

    // Full FIFO with push and pop on the same edge: no drop.
    head = sb.pop_front();
    chk("fullpop_head", 32'(out_data), 32'(head));
    sb.push_back({2'b01, 16'h0200, 8'hEE});
    out_ready = 1'b1;
    bus(1'b1, 1'b0, 16'h0200, 8'hEE);
    out_ready = 1'b0;
    chk("fullpop_drop", 32'(drop_count), 32'd4);
    drain("fullpop", n);
    chk("fullpop_count", 32'(n), 32'd16);
    chk("fullpop_overflow_sticky", 32'(overflow), 32'd1);

    // Reset while draining with 5 entries queued.
    for (int i = 0; i < 5; i++) begin
      bus(1'b1, 1'b0, 16'h0400 + 16'(i), 8'(8'h40 + i));
    end
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);

    // Done marker followed by writes that must be ignored without drops.
    sb.push_back({2'b11, 16'hDEAD, 8'h00});
    bus(1'b1, 1'b0, 16'hDEAD, 8'h00);
    chk("done_flag", 32'(done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus(1'b1, 1'b0, 16'h0300 + 16'(i), 8'(i));
    end
    chk("done_drop", 32'(drop_count), 32'd0);
    chk("done_overflow", 32'(overflow), 32'd0);
    drain("done", n);
    chk("done_count", 32'(n), 32'd1);
    chk("done_sticky", 32'(done), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
